// File: rtl/playbus_sched_pkg.sv
// playbus_pkg: shared states, function codes and source/sink decode for the PlayBus scheduler
// Ports: none (package)
package playbus_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, WRITE = 2'd2, HOLD = 2'd3} state_t;
    typedef enum logic [1:0] {SRC_ROM, SRC_RAM, SRC_SW} src_t;
    typedef enum logic [1:0] {SNK_NONE, SNK_RAM, SNK_LED} sink_t;
    localparam logic [2:0] F_ROM_BUS = 3'd0;
    localparam logic [2:0] F_RAM_BUS = 3'd1;
    localparam logic [2:0] F_SW_BUS  = 3'd2;
    localparam logic [2:0] F_SW_RAM  = 3'd3;
    localparam logic [2:0] F_ROM_RAM = 3'd4;
    localparam logic [2:0] F_SW_LED  = 3'd5;
    localparam logic [2:0] F_ROM_LED = 3'd6;
    localparam logic [2:0] F_RAM_LED = 3'd7;
    function automatic src_t src_of(input logic [2:0] f);
        return (f == F_RAM_BUS || f == F_RAM_LED) ? SRC_RAM :
               (f == F_SW_BUS || f == F_SW_RAM || f == F_SW_LED) ? SRC_SW : SRC_ROM;
    endfunction
    function automatic sink_t sink_of(input logic [2:0] f);
        return (f == F_SW_RAM || f == F_ROM_RAM) ? SNK_RAM :
               (f == F_SW_LED || f == F_ROM_LED || f == F_RAM_LED) ? SNK_LED : SNK_NONE;
    endfunction
endpackage

// File: rtl/playbus_sched_if.sv
// playbus_sched_if: requester handshake and PlayBus control lines
// master: requesters (drive req/req_func/req_add); slave: scheduler (drives grants, bus lines, state)
interface playbus_sched_if #(parameter int NREQ = 2);
    logic [NREQ-1:0]   req;
    logic [3*NREQ-1:0] req_func;
    logic [4*NREQ-1:0] req_add;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   done;
    logic [3:0]        add;
    logic              n_romo;
    logic              n_ramo;
    logic              n_swben;
    logic              n_ramw;
    logic              ledltch;
    logic [1:0]        st;
    modport master (output req, req_func, req_add,
                    input gnt, done, add, n_romo, n_ramo, n_swben, n_ramw, ledltch, st);
    modport slave  (input req, req_func, req_add,
                    output gnt, done, add, n_romo, n_ramo, n_swben, n_ramw, ledltch, st);
endinterface

// File: rtl/playbus_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request after i_ptr
// Ports: i_req requests, i_ptr last winner, o_gnt one-hot winner, o_idx winner index, o_valid any request
module rr_arbiter #(
    parameter int N = 2,
    localparam int PW = N > 1 ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [PW-1:0] o_idx,
    output logic          o_valid
);
    logic [PW-1:0] w_j;
    // scan farthest-to-nearest so the nearest asserted request is written last
    always_comb begin
        o_idx = '0;
        o_valid = 1'b0;
        w_j = '0;
        for (int k = N; k >= 1; k--) begin
            w_j = PW'((int'(i_ptr) + k) % N);
            if (i_req[w_j]) begin
                o_idx = w_j;
                o_valid = 1'b1;
            end
        end
        o_gnt = o_valid ? (N'(1) << o_idx) : '0;
    end
endmodule

// File: rtl/playbus_sched.sv
// playbus_sched: round-robin PlayBus scheduler running setup/write/hold transfers
// Ports: i_ck2hz clock, i_clr async active-high reset, io_bus requester handshake and bus control lines
module playbus_sched
    import playbus_pkg::*;
#(
    parameter int NREQ = 2
) (
    input logic             i_ck2hz,
    input logic             i_clr,
    playbus_sched_if.slave  io_bus
);
    localparam int PW = NREQ > 1 ? $clog2(NREQ) : 1;
    state_t        r_st, w_nxt;
    logic [2:0]    r_func;
    logic [3:0]    r_add;
    logic [NREQ-1:0] r_gnt, r_done, w_win;
    logic          r_ramw, r_ledltch, w_ramw, w_ledltch;
    logic [PW-1:0] r_ptr, w_idx;
    logic          w_valid, w_own, w_grant, w_act;
    src_t          w_src;
    sink_t         w_sink;

    rr_arbiter #(.N(NREQ)) u_arb (
        .i_req  (io_bus.req),
        .i_ptr  (r_ptr),
        .o_gnt  (w_win),
        .o_idx  (w_idx),
        .o_valid(w_valid)
    );

    assign w_own   = |(io_bus.req & r_gnt);
    assign w_grant = (r_st == IDLE) && w_valid;
    assign w_src   = src_of(r_func);
    assign w_sink  = sink_of(r_func);
    assign w_act   = r_st != IDLE;

    always_comb begin
        w_nxt = r_st;
        w_ramw = 1'b0;
        w_ledltch = 1'b0;
        case (r_st)
            IDLE:  w_nxt = w_valid ? SETUP : IDLE;
            SETUP: begin
                // a requester that already released its REQ aborts before any write
                w_nxt = !w_own ? IDLE : (w_sink == SNK_NONE) ? HOLD : WRITE;
                w_ramw = w_own && w_sink == SNK_RAM;
                w_ledltch = w_own && w_sink == SNK_LED;
            end
            WRITE: w_nxt = HOLD;
            HOLD:  w_nxt = w_own ? HOLD : IDLE;
            default: w_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_ck2hz or posedge i_clr) begin
        if (i_clr) r_st <= IDLE;
        else r_st <= w_nxt;
    end

    always_ff @(posedge i_ck2hz or posedge i_clr) begin
        if (i_clr) begin
            r_gnt <= '0;
            r_done <= '0;
            r_add <= '0;
            r_func <= '0;
            r_ramw <= 1'b0;
            r_ledltch <= 1'b0;
            r_ptr <= PW'(NREQ - 1);
        end else begin
            r_ramw <= w_ramw;
            r_ledltch <= w_ledltch;
            r_done <= (w_nxt == HOLD) ? r_gnt : '0;
            if (w_grant) begin
                r_gnt <= w_win;
                r_ptr <= w_idx;
                r_func <= io_bus.req_func[3*w_idx +: 3];
                r_add <= io_bus.req_add[4*w_idx +: 4];
            end else if (w_nxt == IDLE) begin
                r_gnt <= '0;
                r_add <= '0;
            end
        end
    end

    assign io_bus.gnt     = r_gnt;
    assign io_bus.done    = r_done;
    assign io_bus.add     = r_add;
    assign io_bus.st      = r_st;
    assign io_bus.n_romo  = !(w_act && w_src == SRC_ROM);
    assign io_bus.n_ramo  = !(w_act && w_src == SRC_RAM);
    assign io_bus.n_swben = !(w_act && w_src == SRC_SW);
    assign io_bus.n_ramw  = !r_ramw;
    assign io_bus.ledltch = r_ledltch;
endmodule

// File: doc/playbus_sched.md
# playbus_sched

Round-robin bus scheduler for the PlayBus. Up to four requesters, for example the front-panel sequencer and a block-copy engine, post a function code and address. The scheduler grants the shared bus to one requester at a time. It then runs that requester's transfer on the PlayBus control lines (ROM/RAM/switch enables, RAM write, LED latch) using a fixed setup → write → hold sequence with a four-phase REQ/DONE handshake.

## Interface
- NREQ, 2: number of requesters, 1..4.
- CK2HZ  in  1  system clock; all registers update on its rising edge.
- CLR  in  1  reset, asynchronous, active-high.
- REQ  in  NREQ  per-requester request level; held high until DONE is seen, then dropped.
- REQ_FUNC  in  3*NREQ  per-requester function code, slice i = [3i+2:3i]; must be stable while REQ is high.
- REQ_ADD  in  4*NREQ  per-requester address, slice i = [4i+3:4i]; must be stable while REQ is high.
- GNT  out  NREQ  registered one-hot grant; zero when idle.
- DONE  out  NREQ  registered, one-hot; high while the granted transfer is in HOLD.
- ADD  out  4  registered bus address; 0 when idle.
- n_ROMO, n_RAMO, n_SWBEN  out  1 each  active-low source enables.
- n_RAMW  out  1  active-low RAM write; the inverse of an internal registered RAMW.
- LEDLTCH  out  1  registered LED latch strobe.
- St  out  2  state monitor: IDLE=0, SETUP=1, WRITE=2, HOLD=3.

## Operation
- Functions (source → sink):
  - 0 ROM→bus, 1 RAM→bus, 2 SW→bus: no sink.
  - 3 SW→RAM, 4 ROM→RAM.
  - 5 SW→LED, 6 ROM→LED, 7 RAM→LED.
- Arbitration happens only in IDLE with REQ≠0.
  - Winner is the first asserted REQ at or after index ptr+1 (mod NREQ); ptr is the last granted index.
  - On grant, the winner's FUNC and ADD are latched into cur_func and cur_add, GNT is set, and ptr is updated.
- The source enable is driven only in SETUP, WRITE and HOLD, and only for the source of cur_func. It is combinational from the registered St and cur_func.
- State transitions:
  - IDLE → SETUP on grant.
  - SETUP → WRITE if cur_func is 3..7; next_RAMW=1 for functions 3-4, next_LEDLTCH=1 for 5-7.
  - SETUP → HOLD if cur_func is 0..2.
  - SETUP → IDLE, aborted, if the granted REQ is already low. No write occurs, GNT clears, no DONE.
  - WRITE → HOLD unconditionally; next_RAMW and next_LEDLTCH return to 0.
  - HOLD stays while the granted REQ is high, with the source still enabled and DONE high.
  - HOLD → IDLE when the granted REQ is low; GNT, DONE and ADD clear.
- Idle outputs: all enables 1, RAMW=0, LEDLTCH=0, ADD=0.
- Simultaneous requests are resolved only by round-robin.
  - A requester raising REQ during another's transfer waits.
  - A requester re-raising REQ immediately after release cannot win twice in a row while another REQ is pending.
- Reset (CLR=1, at any time including mid-write) forces:
  - St=IDLE, RAMW=0, LEDLTCH=0, GNT=0, DONE=0, ADD=0, ptr=NREQ-1, so requester 0 wins first.
  - All enables inactive immediately.

## Timing
- REQ sampled high at edge k while in IDLE: GNT, ADD and St=SETUP are valid after edge k, and the source is enabled in that cycle.
- Sink strobe (RAMW or LEDLTCH) is high for exactly one cycle, between edges k+1 and k+2.
  - Data is stable one full cycle before the strobe rises and at least one cycle after it falls.
- DONE rises after edge k+2 (HOLD).
- REQ dropped before edge m in HOLD: IDLE after edge m, and the next grant at the earliest after edge m+1.
- Minimum transfer: 4 cycles for functions 3-7, 3 cycles for functions 0-2. One idle cycle always separates transfers.
- Never assert two source enables at once. Never assert RAMW and LEDLTCH together.

## Structure
- playbus_pkg holds:
  - the state enum (2-bit, explicit values above);
  - function-code constants;
  - functions src_of(func), returning ROM/RAM/SW;
  - functions sink_of(func), returning NONE/RAM/LED.
- Sub-module rr_arbiter (parameter N): REQ, ptr → one-hot winner plus index. It is purely combinational; ptr is held in playbus_sched.

## Test plan
- Reset, then REQ[0]=1 with FUNC=4, ADD=5:
  - GNT=01, ADD=5, n_ROMO=0 for SETUP/WRITE/HOLD;
  - n_RAMW=0 for exactly one cycle (WRITE), DONE[0] in HOLD;
  - REQ dropped → IDLE, all enables 1.
- REQ=11 simultaneously, FUNC0=6, FUNC1=7:
  - requester 0 is served first (LEDLTCH pulse, n_ROMO low), then requester 1 (n_RAMO low);
  - with both still re-requesting, the grant order alternates 0,1,0,1.
- FUNC=2 on requester 1: n_SWBEN=0 in SETUP and HOLD, no RAMW/LEDLTCH pulse, St sequence 0,1,3,0.
- Requester 0 drops REQ in SETUP with FUNC=3: return to IDLE, n_RAMW never low, DONE never set.
- CLR pulsed during WRITE of FUNC=5: LEDLTCH, GNT, DONE and St go to 0 immediately. The first post-reset grant goes to requester 0.
- Checker across all runs: at most one of n_ROMO/n_RAMO/n_SWBEN is low, and RAMW and LEDLTCH are never both high.
